// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and block geometry for the
// cache miss fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int MEM_LATENCY       = 4;

    localparam logic [15:0] BLOCK_MASK =
        ~16'((1 << BLOCK_OFFSET_BITS) - 1);

    localparam logic [3:0] CNT_MAX = 4'(WORDS_PER_BLOCK);

endpackage

// File: rtl/fill_counter.sv
// fill_counter: 4-bit counter that saturates at one full block,
// with synchronous clear and count enable.
module fill_counter
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] count
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && count_q < CNT_MAX) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: stalls the CPU on a miss, streams one 8-word block
// from pipelined memory into the data array, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    output logic        fsm_busy,
    output logic        memory_read_en,
    output logic [15:0] memory_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [2:0]  word_offset,
    output logic [15:0] fill_data,
    output logic [15:0] base_addr
);

    fill_state_e state_q;
    fill_state_e state_d;
    logic [15:0] base_addr_q;
    logic [15:0] base_addr_d;

    logic [3:0] issue_cnt;
    logic [3:0] recv_cnt;
    logic       in_fill;
    logic       start;
    logic       issue_en;
    logic       recv_en;
    logic       last_word;

    assign in_fill   = (state_q == FILL);
    assign start     = (state_q == IDLE) && miss_detected;
    assign issue_en  = in_fill && (issue_cnt < CNT_MAX);
    assign recv_en   = in_fill && memory_data_valid;
    assign last_word = recv_en && (recv_cnt == CNT_MAX - 4'd1);

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (in_fill),
        .count (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (recv_en),
        .count (recv_cnt)
    );

    always_comb begin
        state_d     = state_q;
        base_addr_d = base_addr_q;
        if (start) begin
            state_d     = FILL;
            base_addr_d = miss_address & BLOCK_MASK;
        end else if (last_word) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            base_addr_q <= base_addr_d;
        end
    end

    // Busy is combinational so the CPU stalls in the miss cycle itself.
    assign fsm_busy = in_fill || (start && !rst);

    assign memory_read_en   = issue_en;
    assign memory_address   = base_addr_q | {11'b0, issue_cnt[2:0], 1'b0};
    assign write_data_array = recv_en;
    assign write_tag_array  = last_word;
    assign word_offset      = recv_en ? recv_cnt[2:0] : 3'd0;
    assign fill_data        = memory_data;
    assign base_addr        = base_addr_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: pipelined memory stub, transaction-level model,
// directed timeline checks and randomized fills.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic [15:0] memory_data = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  word_offset;
    logic [15:0] fill_data;
    logic [15:0] base_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_offset       (word_offset),
        .fill_data         (fill_data),
        .base_addr         (base_addr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory stub: in-order returns 4 cycles after request
    int          q_ready[$];
    logic [15:0] q_addr[$];
    logic [15:0] data_base = 16'hA000;
    int          stall_pct = 0;
    bit          gap_mode  = 1'b0;
    int          opp       = 0;
    bit          spur      = 1'b0;
    bit          stall_now;

    always @(posedge clk) begin
        if (memory_data_valid && !spur && q_ready.size() > 0) begin
            void'(q_ready.pop_front());
            void'(q_addr.pop_front());
        end
        if (memory_read_en && !rst) begin
            q_ready.push_back(cyc + 4);
            q_addr.push_back(memory_address);
        end
        cyc++;
        #1;
        memory_data_valid = 1'b0;
        memory_data = 16'($urandom);
        if (spur) begin
            memory_data_valid = 1'($urandom_range(0, 1));
        end else if (q_ready.size() > 0 && q_ready[0] <= cyc) begin
            stall_now = 1'b0;
            if (gap_mode) begin
                opp++;
                stall_now = (opp == 3 || opp == 6);
            end else if ($urandom_range(0, 99) < stall_pct) begin
                stall_now = 1'b1;
            end
            if (!stall_now) begin
                memory_data_valid = 1'b1;
                memory_data = data_base + 16'(q_addr[0][3:1]);
            end
        end
    end

    // Transaction-level model: block base, words issued, words received
    bit m_fill = 1'b0;
    int m_base = 0;
    int m_iss  = 0;
    int m_rcv  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill = 1'b0;
            m_base = 0;
            m_iss  = 0;
            m_rcv  = 0;
        end else if (!m_fill) begin
            if (miss_detected) begin
                m_fill = 1'b1;
                m_base = int'(miss_address) & ~32'hF;
                m_iss  = 0;
                m_rcv  = 0;
            end
        end else begin
            if (m_iss < 8) m_iss++;
            if (memory_data_valid) m_rcv++;
            if (m_rcv == 8) m_fill = 1'b0;
        end
    end

    bit chk_on  = 1'b0;
    int wr_cnt  = 0;
    int tag_cnt = 0;
    bit e_busy, e_rd, e_wr, e_tag;

    always @(negedge clk) begin
        if (chk_on) begin
            e_busy = 1'b0;
            e_rd   = 1'b0;
            e_wr   = 1'b0;
            e_tag  = 1'b0;
            if (!rst && m_fill) begin
                e_busy = 1'b1;
                e_rd   = (m_iss < 8);
                e_wr   = memory_data_valid;
                e_tag  = memory_data_valid && (m_rcv == 7);
            end else if (!rst) begin
                e_busy = miss_detected;
            end
            chk("busy", fsm_busy, e_busy);
            chk("read_en", memory_read_en, e_rd);
            if (e_rd) chk("address", memory_address, m_base + 2 * m_iss);
            chk("write_data", write_data_array, e_wr);
            chk("write_tag", write_tag_array, e_tag);
            chk("base_addr", base_addr, m_base);
            if (e_wr) begin
                chk("offset", word_offset, m_rcv % 8);
                chk("fill_data", fill_data, memory_data);
                chk("data_order", fill_data, 16'(data_base + 16'(m_rcv % 8)));
            end
            if (write_data_array) wr_cnt++;
            if (write_tag_array) tag_cnt++;
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && fsm_busy; i++) next();
        chk("idle_timeout", fsm_busy, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && q_ready.size() > 0; i++) next();
        chk("drain_timeout", q_ready.size(), 0);
    endtask

    int w0, t0, lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        miss_detected = 1'b0;
        miss_address = 16'h0;
        repeat (2) next();
        chk("rst_busy", fsm_busy, 1'b0);
        chk("rst_read_en", memory_read_en, 1'b0);
        chk("rst_write_data", write_data_array, 1'b0);
        chk("rst_write_tag", write_tag_array, 1'b0);
        chk("rst_offset", word_offset, 3'd0);
        chk("rst_base", base_addr, 16'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        next();

        // Directed timeline: miss on 0x1236, latency 4, no bubbles
        data_base = 16'hA000;
        miss_detected = 1'b1;
        miss_address = 16'h1236;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            chk("t1_busy", fsm_busy, k <= 12);
            chk("t1_read_en", memory_read_en, k >= 1 && k <= 8);
            if (k >= 1 && k <= 8)
                chk("t1_addr", memory_address, 16'h1230 + 2 * (k - 1));
            chk("t1_write", write_data_array, k >= 5 && k <= 12);
            if (k >= 5 && k <= 12) begin
                chk("t1_offset", word_offset, k - 5);
                chk("t1_data", fill_data, 16'hA000 + k - 5);
            end
            chk("t1_tag", write_tag_array, k == 12);
            next();
            miss_detected = 1'b0;
        end

        // Top-of-memory block: no address wrap
        miss_detected = 1'b1;
        miss_address = 16'hFFFF;
        next();
        miss_detected = 1'b0;
        @(negedge clk);
        chk("top_base", base_addr, 16'hFFF0);
        repeat (7) next();
        @(negedge clk);
        chk("top_last_rd", memory_read_en, 1'b1);
        chk("top_last_addr", memory_address, 16'hFFFE);
        next();
        @(negedge clk);
        chk("top_rd_done", memory_read_en, 1'b0);
        wait_idle(40);

        // Two bubbles in the return stream
        w0 = wr_cnt;
        t0 = tag_cnt;
        gap_mode = 1'b1;
        opp = 0;
        miss_detected = 1'b1;
        miss_address = 16'h4A2C;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!fsm_busy) break;
            lat++;
            next();
            miss_detected = 1'b0;
        end
        chk("gap_stall_len", lat, 15);
        next();
        gap_mode = 1'b0;
        chk("gap_writes", wr_cnt - w0, 8);
        chk("gap_tags", tag_cnt - t0, 1);

        // Reset in cycle 7 of a fill
        w0 = wr_cnt;
        t0 = tag_cnt;
        miss_detected = 1'b1;
        miss_address = 16'h1236;
        for (int k = 0; k < 7; k++) begin
            next();
            miss_detected = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", fsm_busy, 1'b0);
        chk("mid_rst_read_en", memory_read_en, 1'b0);
        chk("mid_rst_write", write_data_array, 1'b0);
        chk("mid_rst_tag", write_tag_array, 1'b0);
        chk("mid_rst_base", base_addr, 16'h0);
        chk("mid_rst_pre_writes", wr_cnt - w0, 2);
        next();
        rst = 1'b0;
        repeat (8) next();
        chk("stale_writes", wr_cnt - w0, 2);
        chk("stale_tags", tag_cnt - t0, 0);
        wait_drain();
        w0 = wr_cnt;
        t0 = tag_cnt;
        miss_detected = 1'b1;
        miss_address = 16'h0040;
        next();
        miss_detected = 1'b0;
        wait_idle(40);
        next();
        chk("refill_writes", wr_cnt - w0, 8);
        chk("refill_tags", tag_cnt - t0, 1);

        // Miss held high across a whole fill
        miss_detected = 1'b1;
        miss_address = 16'h2000;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 12) chk("hold_tag", write_tag_array, 1'b1);
            if (k == 13) begin
                chk("hold_busy13", fsm_busy, 1'b1);
                chk("hold_rd13", memory_read_en, 1'b0);
            end
            if (k == 14) begin
                chk("hold_rd14", memory_read_en, 1'b1);
                chk("hold_addr14", memory_address, 16'h3000);
                chk("hold_base14", base_addr, 16'h3000);
            end
            next();
            if (k == 4) miss_address = 16'h3004;
        end
        miss_detected = 1'b0;
        wait_idle(40);

        // Valid pulses while idle
        wait_drain();
        w0 = wr_cnt;
        spur = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("spur_busy", fsm_busy, 1'b0);
            next();
        end
        spur = 1'b0;
        next();
        next();
        chk("spur_writes", wr_cnt - w0, 0);

        // Randomized fills, random bubbles, random misses during fill
        for (int it = 0; it < 30; it++) begin
            stall_pct = $urandom_range(0, 40);
            data_base = 16'($urandom);
            repeat ($urandom_range(0, 3)) next();
            miss_detected = 1'b1;
            miss_address = 16'($urandom);
            for (int k = 0; k < 20; k++) begin
                next();
                miss_detected = ($urandom_range(0, 3) == 0);
                miss_address = 16'($urandom);
            end
            miss_detected = 1'b0;
            wait_idle(300);
        end
        stall_pct = 0;
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
